// File: rtl/vram_arbiter_if.sv
// Requester, memory and grant signals shared between the VRAM arbiter and its surroundings.
// slave = arbiter side, master = requesters plus the VRAM port.
interface vram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_ack;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              cmd_req;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_ack;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  logic [1:0]        grant;

  modport slave (
    input  disp_req, disp_addr, host_req, host_we, host_addr, host_wdata,
           cmd_req, cmd_addr, cmd_wdata, mem_q,
    output disp_ack, disp_rvalid, disp_rdata, host_ack, host_rvalid, host_rdata,
           cmd_ack, mem_addr, mem_data, mem_wren, grant
  );

  modport master (
    output disp_req, disp_addr, host_req, host_we, host_addr, host_wdata,
           cmd_req, cmd_addr, cmd_wdata, mem_q,
    input  disp_ack, disp_rvalid, disp_rdata, host_ack, host_rvalid, host_rdata,
           cmd_ack, mem_addr, mem_data, mem_wren, grant
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display favoured for up to DISP_BURST grants, then host/cmd round-robin.
// Grants are combinational (zero added latency); read data returns one cycle after the grant.
module vram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int DISP_BURST = 4
) (
  input logic           clock,
  input logic           reset_n,
  vram_arbiter_if.slave bus
);
  localparam int RUN_W = $clog2(DISP_BURST + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DISP_BURST);

  typedef enum logic [1:0] {GNT_IDLE = 2'd0, GNT_DISP = 2'd1, GNT_HOST = 2'd2, GNT_CMD = 2'd3} grant_e;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_DISP = 2'd1, OWN_HOST = 2'd2} owner_e;

  logic [RUN_W-1:0]  disp_run_q, disp_run_d;
  logic              rr_last_cmd_q, rr_last_cmd_d;
  owner_e            rd_owner_q, rd_owner_d;
  grant_e            gnt;
  logic              hc_req;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] data_mux;
  logic              wren_mux;

  assign hc_req = bus.host_req | bus.cmd_req;

  // Reset holds the grant idle so nothing is acked or written while reset_n is low.
  always_comb begin
    gnt = GNT_IDLE;
    if (!reset_n) begin
      gnt = GNT_IDLE;
    end else if (bus.disp_req && ((disp_run_q < RUN_MAX) || !hc_req)) begin
      gnt = GNT_DISP;
    end else if (bus.host_req && bus.cmd_req) begin
      gnt = rr_last_cmd_q ? GNT_HOST : GNT_CMD;
    end else if (bus.host_req) begin
      gnt = GNT_HOST;
    end else if (bus.cmd_req) begin
      gnt = GNT_CMD;
    end
  end

  always_comb begin
    addr_mux = '0;
    data_mux = '0;
    wren_mux = 1'b0;
    case (gnt)
      GNT_DISP: addr_mux = bus.disp_addr;
      GNT_HOST: begin
        addr_mux = bus.host_addr;
        data_mux = bus.host_wdata;
        wren_mux = bus.host_we;
      end
      GNT_CMD: begin
        addr_mux = bus.cmd_addr;
        data_mux = bus.cmd_wdata;
        wren_mux = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    disp_run_d    = '0;
    rr_last_cmd_d = rr_last_cmd_q;
    rd_owner_d    = OWN_NONE;
    case (gnt)
      GNT_DISP: begin
        disp_run_d = (disp_run_q == RUN_MAX) ? disp_run_q : disp_run_q + RUN_W'(1);
        rd_owner_d = OWN_DISP;
      end
      GNT_HOST: begin
        rr_last_cmd_d = 1'b0;
        if (!bus.host_we) rd_owner_d = OWN_HOST;
      end
      GNT_CMD: rr_last_cmd_d = 1'b1;
      default: ;
    endcase
  end

  // rr_last resets to "command" so the first host/command tie goes to the host.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      disp_run_q    <= '0;
      rr_last_cmd_q <= 1'b1;
      rd_owner_q    <= OWN_NONE;
    end else begin
      disp_run_q    <= disp_run_d;
      rr_last_cmd_q <= rr_last_cmd_d;
      rd_owner_q    <= rd_owner_d;
    end
  end

  assign bus.grant       = gnt;
  assign bus.disp_ack    = (gnt == GNT_DISP);
  assign bus.host_ack    = (gnt == GNT_HOST);
  assign bus.cmd_ack     = (gnt == GNT_CMD);
  assign bus.mem_addr    = addr_mux;
  assign bus.mem_data    = data_mux;
  assign bus.mem_wren    = wren_mux;
  assign bus.disp_rvalid = (rd_owner_q == OWN_DISP);
  assign bus.host_rvalid = (rd_owner_q == OWN_HOST);
  assign bus.disp_rdata  = bus.mem_q;
  assign bus.host_rdata  = bus.mem_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: behavioural VRAM, a grant/read-return reference model and directed plus random steps.
module tb_vram_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int DB = 4;

  logic clock;
  logic reset_n;
  logic late_rst;

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DISP_BURST(DB)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural VRAM: read data appears the cycle after the address, old contents on same-cycle write.
  logic [DW-1:0] vmem   [65536];
  logic [DW-1:0] shadow [65536];
  always @(posedge clock) begin
    bus.mem_q <= vmem[bus.mem_addr];
    if (bus.mem_wren) vmem[bus.mem_addr] = bus.mem_data;
  end

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: display streak length, whose turn it is on a host/cmd tie, pending read return.
  int streak;
  bit host_turn;
  int pend;
  logic [DW-1:0] pend_data;
  int g_last;
  int obs_g, obs_wren, obs_addr, obs_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int predict(input bit d, input bit h, input bit c);
    if (d && (streak < DB || !(h || c))) return 1;
    if (h && c) return host_turn ? 2 : 3;
    if (h) return 2;
    if (c) return 3;
    return 0;
  endfunction

  task automatic step();
    int g, ewr, ea, ed;
    @(negedge clock);
    g = reset_n ? predict(bus.disp_req, bus.host_req, bus.cmd_req) : 0;
    ewr = (g == 3) ? 1 : (g == 2) ? int'(bus.host_we) : 0;
    ea  = (g == 1) ? int'(bus.disp_addr) : (g == 2) ? int'(bus.host_addr) : (g == 3) ? int'(bus.cmd_addr) : 0;
    ed  = (g == 2) ? int'(bus.host_wdata) : (g == 3) ? int'(bus.cmd_wdata) : 0;
    obs_g = int'(bus.grant);
    obs_wren = int'(bus.mem_wren);
    obs_addr = int'(bus.mem_addr);
    obs_data = int'(bus.mem_data);
    chk("grant", 32'(bus.grant), 32'(g));
    chk("acks", 32'({bus.disp_ack, bus.host_ack, bus.cmd_ack}), 32'({g == 1, g == 2, g == 3}));
    chk("mem_wren", 32'(bus.mem_wren), 32'(ewr));
    chk("mem_addr", 32'(bus.mem_addr), 32'(ea));
    if (g != 1) chk("mem_data", 32'(bus.mem_data), 32'(ed));
    chk("rvalid", 32'({bus.disp_rvalid, bus.host_rvalid}), 32'({pend == 1, pend == 2}));
    if (pend == 1) chk("disp_rdata", 32'(bus.disp_rdata), 32'(pend_data));
    if (pend == 2) chk("host_rdata", 32'(bus.host_rdata), 32'(pend_data));
    if (late_rst) reset_n = 1'b0;
    @(posedge clock);
    pend = 0;
    if (!reset_n) begin
      streak = 0;
      host_turn = 1'b1;
    end else begin
      streak = (g == 1) ? ((streak < DB) ? streak + 1 : DB) : 0;
      if (g == 1) begin
        pend = 1;
        pend_data = shadow[bus.disp_addr];
      end else if (g == 2) begin
        host_turn = 1'b0;
        if (bus.host_we) shadow[bus.host_addr] = bus.host_wdata;
        else begin
          pend = 2;
          pend_data = shadow[bus.host_addr];
        end
      end else if (g == 3) begin
        host_turn = 1'b1;
        shadow[bus.cmd_addr] = bus.cmd_wdata;
      end
    end
    g_last = g;
    #1;
  endtask

  initial begin
    string pat;
    string gmap;
    int n_ack, n_rv, nz;
    gmap = "IDHC";
    late_rst = 1'b0;
    reset_n = 1'b0;
    streak = 0; host_turn = 1'b1; pend = 0; pend_data = '0; g_last = 0;
    for (int i = 0; i < 65536; i++) begin
      logic [DW-1:0] v;
      v = DW'($urandom);
      vmem[i] = v;
      shadow[i] = v;
    end
    bus.disp_req = 1'b1; bus.disp_addr = 16'h0010;
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 16'h0020; bus.host_wdata = 8'h11;
    bus.cmd_req = 1'b1;  bus.cmd_addr = 16'h0030; bus.cmd_wdata = 8'h22;

    // Reset with every request high: nothing granted or written.
    repeat (2) step();
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_wren", 32'(bus.mem_wren), 32'd0);
    chk("rst_rvalid", 32'({bus.disp_rvalid, bus.host_rvalid}), 32'd0);

    reset_n = 1'b1;
    bus.disp_req = 1'b0; bus.host_we = 1'b0;
    step();
    chk("first_tie_host", 32'(obs_g), 32'd2);
    bus.host_req = 1'b0; bus.cmd_req = 1'b0;
    step();

    // Host write 0xA5 to 0x1234 then read it back.
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 16'h1234; bus.host_wdata = 8'hA5;
    step();
    chk("hw_wren", 32'(obs_wren), 32'd1);
    chk("hw_addr", 32'(obs_addr), 32'h1234);
    chk("hw_data", 32'(obs_data), 32'hA5);
    bus.host_we = 1'b0; bus.host_wdata = 8'h00;
    step();
    chk("hr_rvalid", 32'(bus.host_rvalid), 32'd1);
    chk("hr_rdata", 32'(bus.host_rdata), 32'hA5);
    bus.host_req = 1'b0;
    step();

    // Display alone over addresses 0..9.
    n_ack = 0;
    bus.disp_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.disp_addr = AW'(i);
      step();
      if (obs_g == 1) n_ack++;
    end
    bus.disp_req = 1'b0;
    step();
    chk("disp_alone_acks", 32'(n_ack), 32'd10);

    // All three requesting continuously from a fresh reset.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    bus.disp_req = 1'b1; bus.host_req = 1'b1; bus.cmd_req = 1'b1; bus.host_we = 1'b0;
    pat = "DDDDHDDDDCDDDDH";
    for (int i = 0; i < 15; i++) begin
      step();
      chk("all_seq", 32'(gmap[obs_g]), 32'(pat[i]));
    end
    bus.disp_req = 1'b0; bus.host_req = 1'b0; bus.cmd_req = 1'b0;
    step();

    // Random traffic over a small address window, with occasional reset cycles.
    for (int n = 0; n < 3000; n++) begin
      if (!bus.disp_req || g_last == 1 || $urandom_range(9) == 0) begin
        bus.disp_req = 1'($urandom_range(1));
        bus.disp_addr = AW'($urandom_range(15));
      end
      if (!bus.host_req || g_last == 2 || $urandom_range(9) == 0) begin
        bus.host_req = 1'($urandom_range(1));
        bus.host_we = 1'($urandom_range(1));
        bus.host_addr = AW'($urandom_range(15));
        bus.host_wdata = DW'($urandom);
      end
      if (!bus.cmd_req || g_last == 3 || $urandom_range(9) == 0) begin
        bus.cmd_req = 1'($urandom_range(1));
        bus.cmd_addr = AW'($urandom_range(15));
        bus.cmd_wdata = DW'($urandom);
      end
      reset_n = ($urandom_range(199) != 0);
      step();
    end
    reset_n = 1'b1;
    bus.disp_req = 1'b0; bus.host_req = 1'b0; bus.cmd_req = 1'b0;
    step();

    // Display read granted, then reset sampled at the very next edge.
    bus.disp_req = 1'b1; bus.disp_addr = 16'h0005;
    late_rst = 1'b1;
    step();
    late_rst = 1'b0;
    chk("mid_gnt", 32'(obs_g), 32'd1);
    chk("mid_rvalid", 32'(bus.disp_rvalid), 32'd0);
    step();
    reset_n = 1'b1;
    bus.host_req = 1'b1; bus.cmd_req = 1'b1;
    pat = "DDDDH";
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_seq", 32'(gmap[obs_g]), 32'(pat[i]));
    end
    bus.disp_req = 1'b0; bus.host_req = 1'b0; bus.cmd_req = 1'b0;
    step();

    // Command engine clears the whole memory.
    n_ack = 0; n_rv = 0;
    bus.cmd_req = 1'b1; bus.cmd_wdata = 8'h00;
    for (int a = 0; a < 65536; a++) begin
      bus.cmd_addr = AW'(a);
      step();
      if (obs_g == 3) n_ack++;
      if (bus.disp_rvalid || bus.host_rvalid) n_rv++;
    end
    bus.cmd_req = 1'b0;
    step();
    chk("fill_acks", 32'(n_ack), 32'd65536);
    chk("fill_no_rvalid", 32'(n_rv), 32'd0);
    nz = 0;
    for (int i = 0; i < 65536; i++) if (vmem[i] !== 8'h00) nz++;
    chk("fill_zero", 32'(nz), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
